hpi_responder: RTL and testbench
================================

Name: hpi_responder

Overview:
- Synthesizable responder for the host-port interface (HPI) that the Nios drives through its otg_hpi_* PIO exports.
- Emulates the register and memory view of the USB controller, so the game's keyboard path can run in simulation and on boards without the USB chip.
- Sits at the top level between the nios_system HPI exports and a keycode injection source (test bench or debug switches).
- Replaces the external HPI pins when the emulation build option is selected.

Parameters:
- MEM_WORDS, 256, number of 16-bit words in the emulated memory window (power of two)
- BASE_ADDR, 16'h0500, host byte address of word 0 of the window
- KEY_WORD, 8'h0E, word index inside the window where injected keycodes are written

Ports:
- clk_clk  in  1  system clock, same domain as the Nios PIOs
- reset_reset_n  in  1  asynchronous active-low reset
- hpi_addr  in  2  host register select: 0=DATA, 1=MAILBOX, 2=ADDRESS, 3=STATUS
- hpi_cs_n  in  1  host chip select, active low
- hpi_r_n  in  1  host read strobe, active low
- hpi_w_n  in  1  host write strobe, active low
- hpi_wdata  in  16  host write data (from otg_hpi_data_out_port)
- hpi_rdata  out  16  read data to host (to otg_hpi_data_in_port)
- inj_valid  in  1  keycode injection request
- inj_keycode  in  16  keycode to store at KEY_WORD
- inj_ready  out  1  injection accepted this cycle when high with inj_valid
- mbx_out_valid  in  1  device-side mailbox post request
- mbx_out_data  in  16  device-side mailbox value
- mbx_in_flag  out  1  host has written MAILBOX and the value is not yet consumed
- mbx_in_data  out  16  last host MAILBOX write
- mbx_in_ack  in  1  device-side consume pulse; clears mbx_in_flag

Behaviour:
- Reset values (asynchronous): hpi_rdata=0, inj_ready=0, mbx_in_flag=0, mbx_in_data=0, address register=0, mailbox-out=0, mailbox-out-full=0, memory contents undefined.
- Strobe detection: w_n and r_n are registered once. A write event is a falling edge of w_n while cs_n=0. A read-end event is a rising edge of r_n while cs_n=0 on the previous cycle. Inputs are synchronous to clk_clk; no synchronizers.
- Write, addr 2: the address register loads hpi_wdata (byte address).
- Write, addr 0: memory write at word index (addr_reg-BASE_ADDR)>>1, then addr_reg += 2, wrapping mod 2^16.
  - Out-of-window or odd address: the write is dropped, but the address register still increments.
- Write, addr 1: mbx_in_data<=hpi_wdata and mbx_in_flag<=1. If the flag is already set, the data is overwritten.
- Write, addr 3: ignored.
- Read data: hpi_rdata is registered and valid 2 cycles after r_n falls with cs_n=0. It is held until the next read.
  - addr 0: memory at addr_reg; returns 0 when out of window.
  - addr 1: mailbox-out value; clears mailbox-out-full at read-end.
  - addr 2: addr_reg.
  - addr 3: {14'b0, mbx_in_flag, mbx_out_full}.
- Read-end on addr 0 increments addr_reg by 2. No increment on other registers.
- Injection state machine, states IDLE -> WAIT -> WRITE -> IDLE:
  - IDLE: inj_ready=1.
  - inj_valid=1 captures the keycode and moves to WAIT, where inj_ready=0.
  - WAIT moves to WRITE in the first cycle with no host write event and no host read in progress.
  - WRITE writes the memory word KEY_WORD, then returns to IDLE.
  - Host access always wins the memory port. An injection is never lost; it is only delayed.
- Simultaneous mbx_out_valid and host read-end of MAILBOX: the post wins. Value is updated and full=1.
- Simultaneous mbx_in_ack and host MAILBOX write: the write wins and the flag stays 1.
- cs_n rising mid-strobe aborts the access: no memory update, no increment.
- Reset mid-operation discards any pending injection. inj_ready rises on the first clock after reset release.

Decomposition:
- Shared package hpi_pkg: register-select constants (HPI_DATA=0, HPI_MAILBOX=1, HPI_ADDR=2, HPI_STATUS=3) and status bit positions.
- Sub-module hpi_mem: single-port synchronous RAM, MEM_WORDS x 16, registered read. The port mux and FSM stay in hpi_responder.

Test Plan:
- Write ADDR=0x0500, write DATA 0x1234, 0x5678, write ADDR=0x0500, read DATA twice -> reads 0x1234 then 0x5678; ADDR reads 0x0504.
- inj_valid with 0x001A, no host traffic -> inj_ready low for 2 cycles; ADDR=0x051C, read DATA -> 0x001A.
- Continuous host DATA writes while inj_valid=1 -> inj_ready stays low and injection waits; after host stops, memory word KEY_WORD = injected value and no host word is corrupted.
- Host writes MAILBOX 0xBEEF -> mbx_in_flag=1, mbx_in_data=0xBEEF, STATUS=0x0002; pulse mbx_in_ack -> STATUS=0x0000.
- Write ADDR=0x0000, read DATA -> 0x0000, addr_reg=0x0002; write DATA 0xFFFF out of window -> window memory unchanged.
- Assert reset_reset_n=0 during WAIT with injection pending -> all outputs 0 immediately; after release no memory write occurs and inj_ready=1 next cycle.

Source files
------------

// File: rtl/hpi_pkg.sv
// Shared definitions for the HPI responder: host register selects, status bit
// positions and the keycode injection state encoding.
package hpi_pkg;

    localparam logic [1:0] HPI_DATA    = 2'd0;
    localparam logic [1:0] HPI_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_ADDR    = 2'd2;
    localparam logic [1:0] HPI_STATUS  = 2'd3;

    localparam int STAT_MBX_OUT_FULL = 0;
    localparam int STAT_MBX_IN_FLAG  = 1;

    typedef enum logic [1:0] {
        INJ_IDLE  = 2'd0,
        INJ_WAIT  = 2'd1,
        INJ_WRITE = 2'd2
    } inj_state_t;

    function automatic logic [15:0] status_word(input logic in_flag, input logic out_full);
        logic [15:0] w;
        w = '0;
        w[STAT_MBX_IN_FLAG]  = in_flag;
        w[STAT_MBX_OUT_FULL] = out_full;
        return w;
    endfunction

endpackage

// File: rtl/hpi_mem.sv
// Single-port synchronous RAM with registered read; contents are not reset.
// Read returns the word stored before a same-cycle write.
module hpi_mem #(
    parameter int WORDS = 256,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [WORDS];
    logic [15:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_reg <= mem[addr];
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/hpi_responder.sv
// Emulated USB-controller HPI target: address/data/mailbox/status registers over a
// small memory window, plus a keycode injector that yields the RAM port to the host.
module hpi_responder
    import hpi_pkg::*;
#(
    parameter int          MEM_WORDS = 256,
    parameter logic [15:0] BASE_ADDR = 16'h0500,
    parameter logic [7:0]  KEY_WORD  = 8'h0E
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [1:0]  hpi_addr,
    input  logic        hpi_cs_n,
    input  logic        hpi_r_n,
    input  logic        hpi_w_n,
    input  logic [15:0] hpi_wdata,
    output logic [15:0] hpi_rdata,
    input  logic        inj_valid,
    input  logic [15:0] inj_keycode,
    output logic        inj_ready,
    input  logic        mbx_out_valid,
    input  logic [15:0] mbx_out_data,
    output logic        mbx_in_flag,
    output logic [15:0] mbx_in_data,
    input  logic        mbx_in_ack
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [16:0] WIN_BYTES = 17'(MEM_WORDS * 2);
    localparam logic [AW-1:0] KEY_IDX = AW'(KEY_WORD);

    // Strobe history and read tracking
    logic        w_n_reg, r_n_reg, cs_n_reg;
    logic        read_active_reg, read_active_next;
    logic        wr_event, rd_start, rd_end;

    // Host-visible registers
    logic [15:0] addr_reg;
    logic [15:0] mbx_out_reg;
    logic        mbx_out_full_reg;
    logic        mbx_in_flag_reg;
    logic [15:0] mbx_in_data_reg;
    logic [15:0] hpi_rdata_reg, rdata_next;

    // Read pipeline
    logic        rd_load_reg;
    logic [1:0]  rd_sel_reg;
    logic        rd_inwin_reg;

    // Window decode
    logic [15:0]   offset;
    logic          in_range;
    logic [AW-1:0] word_idx;
    logic          wr_mem;
    logic          host_busy;

    // Injection FSM
    inj_state_t  state_reg, state_next;
    logic        inj_ready_reg, inj_ready_next;
    logic        inj_we;
    logic        inj_accept;
    logic [15:0] keycode_reg;

    // RAM port
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic [15:0]   mem_rdata;

    assign wr_event = !hpi_cs_n && !hpi_w_n && w_n_reg;
    assign rd_start = !hpi_cs_n && !hpi_r_n && r_n_reg;
    assign rd_end   = read_active_reg && !r_n_reg && hpi_r_n && !cs_n_reg;

    // A read is dropped once chip select goes away, so a later r_n rise has no effect.
    always_comb begin
        read_active_next = read_active_reg;
        if (rd_start) begin
            read_active_next = 1'b1;
        end else if (hpi_r_n || hpi_cs_n) begin
            read_active_next = 1'b0;
        end
    end

    assign offset    = addr_reg - BASE_ADDR;
    assign in_range  = ({1'b0, offset} < WIN_BYTES);
    assign word_idx  = offset[AW:1];
    assign wr_mem    = wr_event && (hpi_addr == HPI_DATA) && in_range && !offset[0];
    assign host_busy = wr_event || rd_start || read_active_reg;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            w_n_reg         <= 1'b1;
            r_n_reg         <= 1'b1;
            cs_n_reg        <= 1'b1;
            read_active_reg <= 1'b0;
        end else begin
            w_n_reg         <= hpi_w_n;
            r_n_reg         <= hpi_r_n;
            cs_n_reg        <= hpi_cs_n;
            read_active_reg <= read_active_next;
        end
    end

    // Address register: explicit load, or auto-increment after DATA accesses
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            addr_reg <= '0;
        end else if (wr_event && (hpi_addr == HPI_ADDR)) begin
            addr_reg <= hpi_wdata;
        end else if ((wr_event && (hpi_addr == HPI_DATA)) ||
                     (rd_end && (rd_sel_reg == HPI_DATA))) begin
            addr_reg <= addr_reg + 16'd2;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            mbx_in_flag_reg <= 1'b0;
            mbx_in_data_reg <= '0;
        end else if (wr_event && (hpi_addr == HPI_MAILBOX)) begin
            mbx_in_flag_reg <= 1'b1;
            mbx_in_data_reg <= hpi_wdata;
        end else if (mbx_in_ack) begin
            mbx_in_flag_reg <= 1'b0;
        end
    end

    // A device post in the same cycle as the host consuming the mailbox keeps it full.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            mbx_out_reg      <= '0;
            mbx_out_full_reg <= 1'b0;
        end else if (mbx_out_valid) begin
            mbx_out_reg      <= mbx_out_data;
            mbx_out_full_reg <= 1'b1;
        end else if (rd_end && (rd_sel_reg == HPI_MAILBOX)) begin
            mbx_out_full_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rd_load_reg  <= 1'b0;
            rd_sel_reg   <= HPI_DATA;
            rd_inwin_reg <= 1'b0;
        end else begin
            rd_load_reg <= rd_start;
            if (rd_start) begin
                rd_sel_reg   <= hpi_addr;
                rd_inwin_reg <= in_range;
            end
        end
    end

    always_comb begin
        rdata_next = '0;
        case (rd_sel_reg)
            HPI_DATA:    rdata_next = rd_inwin_reg ? mem_rdata : 16'h0000;
            HPI_MAILBOX: rdata_next = mbx_out_reg;
            HPI_ADDR:    rdata_next = addr_reg;
            default:     rdata_next = status_word(mbx_in_flag_reg, mbx_out_full_reg);
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            hpi_rdata_reg <= '0;
        end else if (rd_load_reg) begin
            hpi_rdata_reg <= rdata_next;
        end
    end

    // Injection FSM: state register
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_reg     <= INJ_IDLE;
            inj_ready_reg <= 1'b0;
            keycode_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            inj_ready_reg <= inj_ready_next;
            if (inj_accept) begin
                keycode_reg <= inj_keycode;
            end
        end
    end

    assign inj_accept = (state_reg == INJ_IDLE) && inj_ready_reg && inj_valid;

    // Injection FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            INJ_IDLE:  if (inj_accept) state_next = INJ_WAIT;
            INJ_WAIT:  if (!host_busy) state_next = INJ_WRITE;
            INJ_WRITE: if (!host_busy) state_next = INJ_IDLE;
            default:   state_next = INJ_IDLE;
        endcase
    end

    // Injection FSM: outputs (ready is registered so it stays low through reset)
    always_comb begin
        inj_we         = (state_reg == INJ_WRITE) && !host_busy;
        inj_ready_next = (state_next == INJ_IDLE);
    end

    // Host and injector never write in the same cycle; host traffic blocks inj_we.
    always_comb begin
        mem_we    = wr_mem || inj_we;
        mem_addr  = inj_we ? KEY_IDX : word_idx;
        mem_wdata = inj_we ? keycode_reg : hpi_wdata;
    end

    hpi_mem #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_mem (
        .clk   (clk_clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign hpi_rdata   = hpi_rdata_reg;
    assign inj_ready   = inj_ready_reg;
    assign mbx_in_flag = mbx_in_flag_reg;
    assign mbx_in_data = mbx_in_data_reg;

endmodule

// File: tb/tb_hpi_responder.sv
// Directed plus randomized bench for hpi_responder, checked against a
// register/memory-level model of the host-visible behaviour.
module tb_hpi_responder;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [1:0]  hpi_addr;
    logic        hpi_cs_n, hpi_r_n, hpi_w_n;
    logic [15:0] hpi_wdata;
    logic [15:0] hpi_rdata;
    logic        inj_valid;
    logic [15:0] inj_keycode;
    logic        inj_ready;
    logic        mbx_out_valid;
    logic [15:0] mbx_out_data;
    logic        mbx_in_flag;
    logic [15:0] mbx_in_data;
    logic        mbx_in_ack;

    int total = 0;
    int bad   = 0;

    // Reference model
    logic [15:0] m_mem [256];
    bit          m_known [256];
    logic [15:0] m_addr;
    logic [15:0] m_mbx_out;
    bit          m_full;
    bit          m_flag;
    logic [15:0] m_in_data;

    hpi_responder dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .hpi_addr      (hpi_addr),
        .hpi_cs_n      (hpi_cs_n),
        .hpi_r_n       (hpi_r_n),
        .hpi_w_n       (hpi_w_n),
        .hpi_wdata     (hpi_wdata),
        .hpi_rdata     (hpi_rdata),
        .inj_valid     (inj_valid),
        .inj_keycode   (inj_keycode),
        .inj_ready     (inj_ready),
        .mbx_out_valid (mbx_out_valid),
        .mbx_out_data  (mbx_out_data),
        .mbx_in_flag   (mbx_in_flag),
        .mbx_in_data   (mbx_in_data),
        .mbx_in_ack    (mbx_in_ack)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_write(input logic [1:0] a, input logic [15:0] d);
        logic [15:0] off;
        off = m_addr - 16'h0500;
        case (a)
            2'd0: begin
                if (off < 16'd512 && off[0] == 1'b0) begin
                    m_mem[off >> 1]   = d;
                    m_known[off >> 1] = 1'b1;
                end
                m_addr = m_addr + 16'd2;
            end
            2'd1: begin m_in_data = d; m_flag = 1'b1; end
            2'd2: m_addr = d;
            default: ;
        endcase
    endtask

    task automatic hw(input logic [1:0] a, input logic [15:0] d);
        hpi_cs_n = 1'b0; hpi_addr = a; hpi_wdata = d; hpi_w_n = 1'b0;
        tick();
        hpi_w_n = 1'b1; hpi_cs_n = 1'b1;
        tick();
        model_write(a, d);
        $display("host write reg=%0d data=%h", a, d);
    endtask

    task automatic rd_check(input logic [1:0] a, input string tag);
        logic [15:0] exp, off, got;
        bit          known;
        known = 1'b1;
        off   = m_addr - 16'h0500;
        case (a)
            2'd0: begin
                if (off < 16'd512) begin
                    exp   = m_mem[off >> 1];
                    known = m_known[off >> 1];
                end else begin
                    exp = 16'h0000;
                end
            end
            2'd1: exp = m_mbx_out;
            2'd2: exp = m_addr;
            default: exp = {14'b0, m_flag, m_full};
        endcase
        hpi_cs_n = 1'b0; hpi_addr = a; hpi_r_n = 1'b0;
        tick();
        tick();
        got = hpi_rdata;
        hpi_r_n = 1'b1;
        tick();
        hpi_cs_n = 1'b1;
        tick();
        if (known) chk(tag, got, exp);
        if (a == 2'd0) m_addr = m_addr + 16'd2;
        if (a == 2'd1) m_full = 1'b0;
        $display("host read reg=%0d data=%h expect=%h known=%0d", a, got, exp, known);
    endtask

    initial begin
        logic [15:0] d;
        reset_reset_n = 1'b0;
        hpi_addr = 2'd0; hpi_cs_n = 1'b1; hpi_r_n = 1'b1; hpi_w_n = 1'b1;
        hpi_wdata = '0; inj_valid = 1'b0; inj_keycode = '0;
        mbx_out_valid = 1'b0; mbx_out_data = '0; mbx_in_ack = 1'b0;
        m_addr = '0; m_mbx_out = '0; m_full = 1'b0; m_flag = 1'b0; m_in_data = '0;
        for (int i = 0; i < 256; i++) begin m_mem[i] = '0; m_known[i] = 1'b0; end

        // Reset state
        tick(); tick();
        chk("rst_rdata", hpi_rdata, 16'h0000);
        chk("rst_ready", {15'b0, inj_ready}, 16'h0000);
        chk("rst_flag", {15'b0, mbx_in_flag}, 16'h0000);
        chk("rst_in_data", mbx_in_data, 16'h0000);
        reset_reset_n = 1'b1;
        tick();
        chk("ready_after_rst", {15'b0, inj_ready}, 16'h0001);
        rd_check(2'd2, "rst_addr");
        rd_check(2'd3, "rst_status");

        // Sequential DATA writes and reads with auto-increment
        hw(2'd2, 16'h0500); hw(2'd0, 16'h1234); hw(2'd0, 16'h5678);
        hw(2'd2, 16'h0500);
        rd_check(2'd0, "data_rd0");
        rd_check(2'd0, "data_rd1");
        rd_check(2'd2, "addr_0504");

        // Injection with idle host: ready low for exactly two cycles
        inj_keycode = 16'h001A; inj_valid = 1'b1;
        tick();
        inj_valid = 1'b0;
        chk("inj_lo1", {15'b0, inj_ready}, 16'h0000);
        tick();
        chk("inj_lo2", {15'b0, inj_ready}, 16'h0000);
        tick();
        chk("inj_hi", {15'b0, inj_ready}, 16'h0001);
        m_mem[14] = 16'h001A; m_known[14] = 1'b1;
        $display("inject key=%h", 16'h001A);
        hw(2'd2, 16'h051C);
        rd_check(2'd0, "inj_word");

        // Long host read holds the injection off
        hw(2'd2, 16'h0540); hw(2'd0, 16'hC0DE); hw(2'd2, 16'h0540);
        hpi_cs_n = 1'b0; hpi_addr = 2'd0; hpi_r_n = 1'b0;
        inj_keycode = 16'h2B2B; inj_valid = 1'b1;
        tick();
        inj_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("inj_blocked", {15'b0, inj_ready}, 16'h0000);
        end
        chk("long_read", hpi_rdata, 16'hC0DE);
        hpi_r_n = 1'b1; tick(); hpi_cs_n = 1'b1; tick();
        tick(); tick();
        chk("inj_done", {15'b0, inj_ready}, 16'h0001);
        m_addr = m_addr + 16'd2;
        m_mem[14] = 16'h2B2B;
        $display("inject key=%h behind long read", 16'h2B2B);

        // Back-to-back host writes racing an injection
        hw(2'd2, 16'h0580);
        inj_keycode = 16'h3C3C;
        for (int i = 0; i < 8; i++) begin
            d = 16'($urandom);
            hpi_cs_n = 1'b0; hpi_addr = 2'd0; hpi_wdata = d; hpi_w_n = 1'b0;
            if (i == 0) inj_valid = 1'b1;
            tick();
            if (i == 0) chk("inj_race_lo", {15'b0, inj_ready}, 16'h0000);
            inj_valid = 1'b0; hpi_w_n = 1'b1;
            tick();
            model_write(2'd0, d);
            $display("host write reg=0 data=%h (racing inject)", d);
        end
        hpi_cs_n = 1'b1;
        tick(); tick(); tick();
        m_mem[14] = 16'h3C3C;
        chk("race_ready", {15'b0, inj_ready}, 16'h0001);
        hw(2'd2, 16'h051C);
        rd_check(2'd0, "race_key");
        hw(2'd2, 16'h0580);
        for (int i = 0; i < 8; i++) rd_check(2'd0, "race_host");

        // Mailbox in
        hw(2'd1, 16'hBEEF);
        chk("mbx_flag", {15'b0, mbx_in_flag}, 16'h0001);
        chk("mbx_data", mbx_in_data, 16'hBEEF);
        rd_check(2'd3, "status_in");
        mbx_in_ack = 1'b1; tick(); mbx_in_ack = 1'b0; m_flag = 1'b0;
        rd_check(2'd3, "status_acked");
        hpi_cs_n = 1'b0; hpi_addr = 2'd1; hpi_wdata = 16'h1357; hpi_w_n = 1'b0; mbx_in_ack = 1'b1;
        tick();
        mbx_in_ack = 1'b0; hpi_w_n = 1'b1; hpi_cs_n = 1'b1;
        tick();
        model_write(2'd1, 16'h1357);
        chk("ack_vs_wr_flag", {15'b0, mbx_in_flag}, 16'h0001);
        chk("ack_vs_wr_data", mbx_in_data, 16'h1357);

        // Mailbox out, including a post colliding with the read-end
        mbx_out_valid = 1'b1; mbx_out_data = 16'hCAFE; tick(); mbx_out_valid = 1'b0;
        m_mbx_out = 16'hCAFE; m_full = 1'b1;
        rd_check(2'd3, "status_full");
        rd_check(2'd1, "mbx_out_rd");
        rd_check(2'd3, "status_consumed");
        mbx_out_valid = 1'b1; mbx_out_data = 16'h1111; tick(); mbx_out_valid = 1'b0;
        hpi_cs_n = 1'b0; hpi_addr = 2'd1; hpi_r_n = 1'b0;
        tick(); tick();
        chk("mbx_out_1111", hpi_rdata, 16'h1111);
        hpi_r_n = 1'b1; mbx_out_valid = 1'b1; mbx_out_data = 16'h2222;
        tick();
        mbx_out_valid = 1'b0; hpi_cs_n = 1'b1;
        tick();
        m_mbx_out = 16'h2222; m_full = 1'b1;
        rd_check(2'd3, "post_wins");
        rd_check(2'd1, "post_value");

        // Window boundaries
        hw(2'd2, 16'h0000);
        rd_check(2'd0, "below_window");
        rd_check(2'd2, "addr_0002");
        hw(2'd0, 16'hFFFF);
        hw(2'd2, 16'h0501); hw(2'd0, 16'h7777);
        rd_check(2'd2, "odd_incr");
        hw(2'd2, 16'h0500);
        rd_check(2'd0, "odd_dropped");
        hw(2'd2, 16'hFFFE); hw(2'd0, 16'hAAAA);
        rd_check(2'd2, "addr_wrap");
        hw(2'd2, 16'h06FE); hw(2'd0, 16'h5A5A); hw(2'd0, 16'hDEAD);
        hw(2'd2, 16'h06FE);
        rd_check(2'd0, "last_word");
        rd_check(2'd0, "above_window");

        // Read aborted by chip select
        hw(2'd2, 16'h0500);
        hpi_cs_n = 1'b0; hpi_addr = 2'd0; hpi_r_n = 1'b0;
        tick();
        hpi_cs_n = 1'b1;
        tick();
        hpi_r_n = 1'b1;
        tick();
        rd_check(2'd2, "abort_no_incr");

        // Random traffic
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 5))
                0: hw(2'd2, 16'h0500 + 16'(2 * $urandom_range(0, 299)));
                1: hw(2'd0, 16'($urandom));
                2: rd_check(2'd0, "rand_data");
                3: rd_check(2'd2, "rand_addr");
                4: begin
                    d = 16'($urandom);
                    chk("rand_inj_rdy", {15'b0, inj_ready}, 16'h0001);
                    inj_keycode = d; inj_valid = 1'b1; tick(); inj_valid = 1'b0;
                    tick(); tick();
                    m_mem[14] = d; m_known[14] = 1'b1;
                    $display("inject key=%h", d);
                end
                default: begin
                    hw(2'd1, 16'($urandom));
                    rd_check(2'd3, "rand_status");
                end
            endcase
        end
        hw(2'd2, 16'h051C);
        rd_check(2'd0, "rand_key");

        // Reset while an injection waits
        hw(2'd2, 16'h051C); hw(2'd0, 16'hAAAA);
        hw(2'd1, 16'h4444);
        hw(2'd2, 16'h0500);
        rd_check(2'd0, "pre_rst_rd");
        inj_keycode = 16'h1111; inj_valid = 1'b1;
        tick();
        inj_valid = 1'b0;
        reset_reset_n = 1'b0;
        #1;
        chk("arst_rdata", hpi_rdata, 16'h0000);
        chk("arst_ready", {15'b0, inj_ready}, 16'h0000);
        chk("arst_flag", {15'b0, mbx_in_flag}, 16'h0000);
        chk("arst_in_data", mbx_in_data, 16'h0000);
        m_addr = '0; m_mbx_out = '0; m_full = 1'b0; m_flag = 1'b0; m_in_data = '0;
        tick(); tick();
        reset_reset_n = 1'b1;
        tick();
        chk("rel_ready", {15'b0, inj_ready}, 16'h0001);
        rd_check(2'd2, "rel_addr");
        rd_check(2'd3, "rel_status");
        hw(2'd2, 16'h051C);
        rd_check(2'd0, "no_stale_inj");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
